dct_transpose_buf: RTL and testbench
====================================

Name: dct_transpose_buf

Overview:
- Ping-pong 8x8 transpose memory between the row-pass and column-pass 8-point DCT stages of the 2D DCT.
- Accepts one 8-coefficient row per handshake from the row-pass DCT and applies an optional rounding right-shift.
- After a full block is stored, emits the block column by column to the column-pass DCT.
- Two banks allow continuous streaming: one bank fills while the other drains.

Parameters:
- W, 18, input coefficient width, signed (row DCT output width for 8-bit input, N+10 with N=8).
- SHIFT, 2, rounding right-shift applied on write; 0 = pass-through.
- OW, W-SHIFT, output coefficient width, signed; derived, not overridden.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_row holds a valid row.
- in_ready  output  1  buffer can accept a row this cycle.
- in_row  input  8 x W  row coefficients, element k = frequency index k, signed.
- out_valid  output  1  out_col holds a valid column.
- out_ready  input  1  downstream accepts the column this cycle.
- out_col  output  8 x OW  column; element r = row r of the stored block, signed.
- out_col_idx  output  3  index (0..7) of the column currently presented.
- out_last  output  1  high with column 7 of a block.

Behaviour:
- One clock, clk. Reset is asynchronous, active-low: rst_n, as used throughout the codebase.
- Reset clears both banks' storage, full flags, wr_bank, rd_bank, row counter and column counter.
- Reset values: in_ready=1, out_valid=0, out_col=0, out_col_idx=0, out_last=0.
- Reset mid-block discards all partial and complete blocks; there is no recovery.
- Storage: bank[2][8 rows][8 cols] of OW bits each, plus per-bank full flag, wr_bank/rd_bank bits, wr_row counter (3b), rd_col counter (3b).
- Write arithmetic: SHIFT>0 stores (x + 2^(SHIFT-1)) >>> SHIFT, using a W+1-bit sum then truncating to OW. No saturation; the range is guaranteed by the upstream DCT. SHIFT=0 stores x unchanged.
- Write rule: in_ready = !full[wr_bank]. It depends on registered state only and has no combinational path from out_ready.
- On in_valid && in_ready: bank[wr_bank][wr_row][k] <= scaled in_row[k], and wr_row increments.
- When wr_row==7 is accepted: full[wr_bank] <= 1, wr_bank toggles, wr_row wraps to 0.
- Read rule: out_valid = full[rd_bank]; out_col[r] = bank[rd_bank][r][rd_col]. This is a combinational mux from registers; out_col is 0 while out_valid=0.
- out_col_idx = rd_col; out_last = out_valid && rd_col==7.
- On out_valid && out_ready: rd_col increments.
- When rd_col==7 is accepted: full[rd_bank] <= 0, rd_bank toggles, rd_col wraps to 0.
- Latency: column 0 is presented in the cycle after the 8th row's handshake edge.
- Throughput: with out_ready held high, 1 row in and 1 column out per cycle sustained, zero bubbles.
- Both banks full: in_ready=0 and the input stalls until the read side releases a bank.
- A released bank becomes writable in the cycle after its last column handshake, never the same cycle.
- Simultaneous write to one bank and read from the other in the same cycle is legal and independent.
- Holding rule: with out_ready low, out_col, out_col_idx and out_last stay stable.
- in_valid may drop between rows; partial blocks wait indefinitely.

Decomposition:
- Shared package dct_pkg:
  - constants DCT_PTS=8 and DCT_IN_W=18;
  - typedef coef_row_t for the 8 x W vector;
  - function round_shift(value, shift) for the rounding shift, shared with the later column-pass output stage.
- One natural sub-module: transpose_bank. It holds one 8x8 register array with a row-write port and a column-read mux and is instantiated twice; the top keeps flags, counters and handshakes.

Test Plan:
- Identity block, SHIFT=0, out_ready=1: rows r with element c = 10r+c, 8 consecutive cycles.
  - out_valid rises the cycle after row 7.
  - Column c element r = 10r+c.
  - out_last on column 7 only.
- Rounding, SHIFT=2: a row of {5, 6, -5, -6, 2, -2, 131071, -131072}.
  - Output row entries = {1, 2, -1, -1, 1, 0, 32768, -32768}, wrapped/truncated to OW=16 bits.
- Back-to-back streaming: 4 blocks of 8 rows with in_valid and out_ready constantly high.
  - in_ready never drops.
  - 32 columns out contiguously, block k columns matching block k rows.
- Backpressure: out_ready=0 while 16 rows are offered.
  - in_ready=0 after row 16 is accepted.
  - out_col stable throughout.
  - Raise out_ready: 8 columns of block 0 drain, then in_ready returns the cycle after column 7.
- Random valid/ready toggling (50% each) over 20 blocks against a software transpose model: zero mismatches, no lost or duplicated columns.
- Reset assertion after 3 rows of a block and with one full block pending:
  - All outputs return to reset values immediately (asynchronous).
  - After release, a fresh block transposes correctly with no stale data.

Source files
------------

// File: rtl/dct_pkg.sv
// Shared 2D-DCT constants, row type and the rounding shift used by both passes.
package dct_pkg;

    localparam int DCT_PTS  = 8;
    localparam int DCT_IN_W = 18;

    typedef logic [DCT_PTS-1:0][DCT_IN_W-1:0] coef_row_t;

    // Round-half-up arithmetic right shift. Callers sign-extend into the 32-bit
    // argument and truncate the result to their own width; the sum cannot
    // overflow 32 bits for any coefficient width used in the DCT pipeline.
    function automatic logic signed [31:0] round_shift(input logic signed [31:0] value,
                                                       input int                 shift);
        logic signed [31:0] bias;
        if (shift == 0) begin
            return value;
        end
        bias = 32'sd1 <<< (shift - 1);
        return (value + bias) >>> shift;
    endfunction

endpackage

// File: rtl/dct_transpose_buf_bank.sv
// One 8x8 coefficient bank: whole-row write port, whole-column read mux.
module transpose_bank
    import dct_pkg::*;
#(
    parameter int OW = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_en,
    input  logic [2:0]                   wr_row,
    input  logic [DCT_PTS-1:0][OW-1:0]   wr_data,
    input  logic [2:0]                   rd_col,
    output logic [DCT_PTS-1:0][OW-1:0]   rd_data
);

    logic [DCT_PTS-1:0][DCT_PTS-1:0][OW-1:0] mem;   // [row][col]

    // Store a full row per write; reset wipes the bank so no stale block survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem <= '0;
        end else if (wr_en) begin
            mem[wr_row] <= wr_data;
        end
    end

    // Gather element rd_col of every row to form one column.
    always_comb begin
        rd_data = '0;
        for (int r = 0; r < DCT_PTS; r++) begin
            rd_data[r] = mem[r][rd_col];
        end
    end

endmodule

// File: rtl/dct_transpose_buf.sv
// Ping-pong 8x8 transpose buffer between the row-pass and column-pass DCTs.
module dct_transpose_buf
    import dct_pkg::*;
#(
    parameter int W     = DCT_IN_W,
    parameter int SHIFT = 2
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [DCT_PTS-1:0][W-1:0]          in_row,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [DCT_PTS-1:0][W-SHIFT-1:0]    out_col,
    output logic [2:0]                         out_col_idx,
    output logic                               out_last
);

    localparam int OW = W - SHIFT;

    logic [1:0]                       full;
    logic [1:0]                       full_nxt;
    logic                             wr_bank;
    logic                             rd_bank;
    logic [2:0]                       wr_row;
    logic [2:0]                       rd_col;
    logic                             wr_fire;
    logic                             rd_fire;
    logic                             wr_done;
    logic                             rd_done;
    logic [DCT_PTS-1:0][OW-1:0]       scaled;
    logic [1:0][DCT_PTS-1:0][OW-1:0]  bank_col;

    // Handshake status comes from registers only, so no ready-to-ready path exists.
    assign in_ready    = !full[wr_bank];
    assign out_valid   = full[rd_bank];
    assign wr_fire     = in_valid && in_ready;
    assign rd_fire     = out_valid && out_ready;
    assign wr_done     = wr_fire && (wr_row == 3'd7);
    assign rd_done     = rd_fire && (rd_col == 3'd7);
    assign out_col_idx = rd_col;
    assign out_last    = out_valid && (rd_col == 3'd7);
    assign out_col     = out_valid ? bank_col[rd_bank] : '0;

    // Rounding shift on the write side; upstream guarantees the result fits OW.
    always_comb begin
        scaled = '0;
        for (int k = 0; k < DCT_PTS; k++) begin
            scaled[k] = OW'(round_shift(32'($signed(in_row[k])), SHIFT));
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        transpose_bank #(.OW(OW)) u_bank (
            .clk     (clk),
            .rst_n   (rst_n),
            .wr_en   (wr_fire && (wr_bank == 1'(b))),
            .wr_row  (wr_row),
            .wr_data (scaled),
            .rd_col  (rd_col),
            .rd_data (bank_col[b])
        );
    end

    // Fill and drain always target different banks, so both updates can apply together.
    always_comb begin
        full_nxt = full;
        if (wr_done) full_nxt[wr_bank] = 1'b1;
        if (rd_done) full_nxt[rd_bank] = 1'b0;
    end

    // Bank flags, bank pointers and row/column counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full    <= '0;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_row  <= '0;
            rd_col  <= '0;
        end else begin
            full <= full_nxt;
            if (wr_fire) begin
                wr_row <= wr_row + 3'd1;
                if (wr_done) wr_bank <= !wr_bank;
            end
            if (rd_fire) begin
                rd_col <= rd_col + 3'd1;
                if (rd_done) rd_bank <= !rd_bank;
            end
        end
    end

endmodule

// File: tb/tb_dct_transpose_buf.sv
// Directed bench for dct_transpose_buf: a SHIFT=2 and a SHIFT=0 instance share stimulus.
module tb_dct_transpose_buf;
    import dct_pkg::*;

    typedef logic [7:0][15:0] col_m_t;
    typedef logic [7:0][17:0] col_z_t;

    logic      clk = 1'b0;
    logic      rst_n = 1'b0;
    logic      in_valid = 1'b0;
    logic      out_ready = 1'b0;
    coef_row_t in_row = '0;

    logic      in_ready, out_valid, out_last;
    col_m_t    out_col;
    logic [2:0] out_col_idx;
    logic      z_in_ready, z_out_valid, z_out_last;
    col_z_t    z_out_col;
    logic [2:0] z_out_col_idx;

    dct_transpose_buf #(.W(18), .SHIFT(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_row(in_row), .out_valid(out_valid), .out_ready(out_ready),
        .out_col(out_col), .out_col_idx(out_col_idx), .out_last(out_last)
    );

    dct_transpose_buf #(.W(18), .SHIFT(0)) dut_z (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(z_in_ready),
        .in_row(in_row), .out_valid(z_out_valid), .out_ready(out_ready),
        .out_col(z_out_col), .out_col_idx(z_out_col_idx), .out_last(z_out_last)
    );

    always #5 clk = ~clk;

    int        checks = 0;
    int        errors = 0;
    col_m_t    q_m[$];
    col_z_t    q_z[$];
    coef_row_t part[8];
    int        prow = 0;
    logic [2:0] mcol = 3'd0;

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected SHIFT=2 storage: round half up, keep 16 bits.
    function automatic logic [15:0] rs2(input logic [17:0] x);
        logic [18:0] s;
        s = {x[17], x} + 19'd2;
        return s[17:2];
    endfunction

    function automatic coef_row_t idrow(input int r);
        coef_row_t row;
        for (int c = 0; c < 8; c++) row[c] = 18'(10 * r + c);
        return row;
    endfunction

    function automatic coef_row_t srow(input int b, input int r);
        coef_row_t row;
        for (int c = 0; c < 8; c++) row[c] = 18'(b * 4096 - r * 300 + c * 17 - 1000);
        return row;
    endfunction

    function automatic coef_row_t rrow();
        coef_row_t row;
        for (int c = 0; c < 8; c++) row[c] = 18'($urandom);
        return row;
    endfunction

    task automatic model_reset();
        q_m.delete();
        q_z.delete();
        prow = 0;
        mcol = 3'd0;
    endtask

    // One clock cycle: drive after the falling edge, check against the model, then
    // apply the handshakes the model predicts for the coming rising edge.
    task automatic cyc(input logic v, input coef_row_t row, input logic rdy, output logic acc);
        int     fb;
        logic   eir, eov;
        col_m_t cm;
        col_z_t cz;
        col_m_t nm;
        col_z_t nz;
        @(negedge clk);
        in_valid  = v;
        in_row    = row;
        out_ready = rdy;
        #1;
        fb  = (q_m.size() + 7) / 8;
        eir = (fb < 2);
        eov = (fb > 0);
        cm  = '0;
        cz  = '0;
        if (eov) begin
            cm = q_m[0];
            cz = q_z[0];
        end
        chk("in_ready", in_ready, eir);
        chk("z_in_ready", z_in_ready, eir);
        chk("out_valid", out_valid, eov);
        chk("z_out_valid", z_out_valid, eov);
        chk("out_col", out_col, cm);
        chk("z_out_col", z_out_col, cz);
        chk("out_col_idx", out_col_idx, mcol);
        chk("z_out_col_idx", z_out_col_idx, mcol);
        chk("out_last", out_last, eov && (mcol == 3'd7));
        chk("z_out_last", z_out_last, eov && (mcol == 3'd7));
        acc = v && eir;
        if (rdy && eov) begin
            void'(q_m.pop_front());
            void'(q_z.pop_front());
            mcol = mcol + 3'd1;
        end
        if (acc) begin
            part[prow] = row;
            prow++;
            if (prow == 8) begin
                for (int c = 0; c < 8; c++) begin
                    for (int r = 0; r < 8; r++) begin
                        nm[r] = rs2(part[r][c]);
                        nz[r] = part[r][c];
                    end
                    q_m.push_back(nm);
                    q_z.push_back(nz);
                end
                prow = 0;
            end
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1'b1);
        chk({tag, "_out_valid"}, out_valid, 1'b0);
        chk({tag, "_out_col"}, out_col, '0);
        chk({tag, "_out_col_idx"}, out_col_idx, 3'd0);
        chk({tag, "_out_last"}, out_last, 1'b0);
        chk({tag, "_z_out_valid"}, z_out_valid, 1'b0);
        chk({tag, "_z_out_col"}, z_out_col, '0);
    endtask

    task automatic identity_block(input string tag);
        logic acc;
        for (int r = 0; r < 8; r++) cyc(1'b1, idrow(r), 1'b1, acc);
        for (int c = 0; c < 8; c++) begin
            cyc(1'b0, '0, 1'b1, acc);
            chk({tag, "_valid"}, z_out_valid, 1'b1);
            for (int r = 0; r < 8; r++) chk({tag, "_elem"}, z_out_col[r], 18'(10 * r + c));
            chk({tag, "_last"}, z_out_last, c == 7);
        end
        cyc(1'b0, '0, 1'b1, acc);
        chk({tag, "_after_valid"}, z_out_valid, 1'b0);
    endtask

    initial begin
        logic        acc;
        int          n;
        int          rows_sent;
        coef_row_t   rr;
        logic [15:0] hr[8];

        // Reset state
        #1;
        chk_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Identity block through the pass-through instance
        identity_block("ident");

        // Rounding row
        rr[0] = 18'(5);      rr[1] = 18'(6);       rr[2] = 18'(-5);     rr[3] = 18'(-6);
        rr[4] = 18'(2);      rr[5] = 18'(-2);      rr[6] = 18'(131071); rr[7] = 18'(-131072);
        hr[0] = 16'd1;       hr[1] = 16'd2;        hr[2] = 16'hFFFF;    hr[3] = 16'hFFFF;
        hr[4] = 16'd1;       hr[5] = 16'd0;        hr[6] = 16'h8000;    hr[7] = 16'h8000;
        cyc(1'b1, rr, 1'b1, acc);
        for (int r = 1; r < 8; r++) cyc(1'b1, '0, 1'b1, acc);
        for (int c = 0; c < 8; c++) begin
            cyc(1'b0, '0, 1'b1, acc);
            chk("round_elem", out_col[0], hr[c]);
            chk("round_zero_rows", out_col[7:1], '0);
        end

        // Back-to-back streaming of 4 blocks
        for (int b = 0; b < 4; b++) begin
            for (int r = 0; r < 8; r++) begin
                cyc(1'b1, srow(b, r), 1'b1, acc);
                chk("stream_accept", acc, 1'b1);
            end
        end
        for (int c = 0; c < 8; c++) cyc(1'b0, '0, 1'b1, acc);

        // Backpressure: two blocks fill, third stalls, then drain
        n = 0;
        for (int i = 0; i < 40 && n < 16; i++) begin
            cyc(1'b1, srow(5 + n / 8, n % 8), 1'b0, acc);
            if (acc) n++;
        end
        chk("bp_rows_taken", n, 16);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, srow(9, 0), 1'b0, acc);
            chk("bp_stall", in_ready, 1'b0);
        end
        for (int c = 0; c < 8; c++) cyc(1'b0, '0, 1'b1, acc);
        cyc(1'b0, '0, 1'b1, acc);
        chk("bp_ready_back", in_ready, 1'b1);
        for (int c = 0; c < 7; c++) cyc(1'b0, '0, 1'b1, acc);

        // Random valid/ready over 20 blocks
        rows_sent = 0;
        for (int i = 0; i < 4000 && (rows_sent < 160 || q_m.size() > 0); i++) begin
            cyc((rows_sent < 160) ? 1'($urandom % 2) : 1'b0, rrow(), 1'($urandom % 2), acc);
            if (acc) rows_sent++;
        end
        chk("rand_rows", rows_sent, 160);
        chk("rand_drained", q_m.size(), 0);

        // Reset with one full block pending and 3 rows of the next
        for (int r = 0; r < 8; r++) cyc(1'b1, srow(11, r), 1'b0, acc);
        cyc(1'b1, srow(12, 0), 1'b1, acc);
        cyc(1'b1, srow(12, 1), 1'b1, acc);
        cyc(1'b1, srow(12, 2), 1'b0, acc);
        @(posedge clk);
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        identity_block("post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
